// File: rtl/mdu_ctrl_pkg.sv
// Shared encodings for the multiply/divide unit: instruction field constants, op decode and FSM states.
// The divide ops decode only when MDU_DIV_EN is defined; otherwise they decode as MD_NONE.
package mdu_ctrl_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] FUNC_MFHI  = 6'h10;
  localparam logic [5:0] FUNC_MTHI  = 6'h11;
  localparam logic [5:0] FUNC_MFLO  = 6'h12;
  localparam logic [5:0] FUNC_MTLO  = 6'h13;
  localparam logic [5:0] FUNC_MULT  = 6'h18;
  localparam logic [5:0] FUNC_MULTU = 6'h19;
  localparam logic [5:0] FUNC_DIV   = 6'h1A;
  localparam logic [5:0] FUNC_DIVU  = 6'h1B;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8
  } md_op_e;

  function automatic md_op_e md_decode(input logic [31:0] instr);
    md_op_e op;
    op = MD_NONE;
    if (instr[31:26] == OP_SPECIAL) begin
      case (instr[5:0])
        FUNC_MULT:  op = MD_MULT;
        FUNC_MULTU: op = MD_MULTU;
`ifdef MDU_DIV_EN
        FUNC_DIV:   op = MD_DIV;
        FUNC_DIVU:  op = MD_DIVU;
`endif
        FUNC_MTHI:  op = MD_MTHI;
        FUNC_MTLO:  op = MD_MTLO;
        FUNC_MFHI:  op = MD_MFHI;
        FUNC_MFLO:  op = MD_MFLO;
        default:    op = MD_NONE;
      endcase
    end else begin
      op = MD_NONE;
    end
    return op;
  endfunction

  function automatic logic md_is_start(input md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath fed from the operands captured at the start edge.
// The divider exists only when MDU_DIV_EN is defined; a zero divisor suppresses the HI/LO write.
module mdu_arith
  import mdu_ctrl_pkg::*;
(
  input  md_op_e      op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        we_o
);

  logic signed [63:0] prod_signed_s;
  logic        [63:0] prod_unsigned_s;
`ifdef MDU_DIV_EN
  logic        [31:0] divisor_s;
  logic signed [31:0] quot_signed_s;
  logic signed [31:0] rem_signed_s;
  logic        [31:0] quot_unsigned_s;
  logic        [31:0] rem_unsigned_s;
`endif

  // Products and (optionally) quotient/remainder, then select by the captured op
  always_comb begin
    prod_signed_s   = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
    prod_unsigned_s = {32'd0, a_i} * {32'd0, b_i};
`ifdef MDU_DIV_EN
    // Substitute 1 for a zero divisor so the arithmetic stays defined; the write is dropped anyway
    divisor_s       = (b_i == 32'd0) ? 32'd1 : b_i;
    quot_signed_s   = $signed(a_i) / $signed(divisor_s);
    rem_signed_s    = $signed(a_i) % $signed(divisor_s);
    quot_unsigned_s = a_i / divisor_s;
    rem_unsigned_s  = a_i % divisor_s;
`endif
    hi_o = 32'd0;
    lo_o = 32'd0;
    we_o = 1'b0;
    case (op_i)
      MD_MULT: begin
        {hi_o, lo_o} = prod_signed_s;
        we_o         = 1'b1;
      end
      MD_MULTU: begin
        {hi_o, lo_o} = prod_unsigned_s;
        we_o         = 1'b1;
      end
`ifdef MDU_DIV_EN
      MD_DIV: begin
        hi_o = rem_signed_s;
        lo_o = quot_signed_s;
        we_o = (b_i != 32'd0);
      end
      MD_DIVU: begin
        hi_o = rem_unsigned_s;
        lo_o = quot_unsigned_s;
        we_o = (b_i != 32'd0);
      end
`endif
      default: begin
        hi_o = 32'd0;
        lo_o = 32'd0;
        we_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle MDU controller: HI/LO registers, IDLE/BUSY sequencer, D-stage stall and mfhi/mflo forwarding.
// Define MDU_DIV_EN to build div/divu; without it they are no-ops.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] instrEX,
  input  logic [31:0] instrD,
  input  logic [31:0] rsdataEX,
  input  logic [31:0] rtdataEX,
  output logic        busy,
  output logic        stallD,
  output logic [31:0] mdOutEX,
  output logic        RegWrite,
  output logic [31:0] RegData,
  output logic [4:0]  RegAddr
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  mdu_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;
  md_op_e             op_q, op_d;
  logic [31:0]        a_q, a_d;
  logic [31:0]        b_q, b_d;

  md_op_e             ex_op_s;
  md_op_e             d_op_s;
  logic               start_s;
  logic               mf_read_s;
  logic [31:0]        arith_hi_s;
  logic [31:0]        arith_lo_s;
  logic               arith_we_s;
  logic               unused_bits_s;

  assign ex_op_s       = md_decode(instrEX);
  assign d_op_s        = md_decode(instrD);
  assign start_s       = (state_q == ST_IDLE) && md_is_start(ex_op_s);
  assign unused_bits_s = ^{instrEX[25:16], instrEX[10:6], instrD[25:6]};

  mdu_arith u_arith (
    .op_i (op_q),
    .a_i  (a_q),
    .b_i  (b_q),
    .hi_o (arith_hi_s),
    .lo_o (arith_lo_s),
    .we_o (arith_we_s)
  );

  // Next-state: start capture, mthi/mtlo writes in IDLE, countdown and completion write in BUSY
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    case (state_q)
      ST_IDLE: begin
        if (start_s) begin
          state_d = ST_BUSY;
          op_d    = ex_op_s;
          a_d     = rsdataEX;
          b_d     = rtdataEX;
`ifdef MDU_DIV_EN
          if ((ex_op_s == MD_DIV) || (ex_op_s == MD_DIVU)) begin
            cnt_d = CNT_W'(DIV_CYCLES - 1);
          end else begin
            cnt_d = CNT_W'(MULT_CYCLES - 1);
          end
`else
          cnt_d   = CNT_W'(MULT_CYCLES - 1);
`endif
        end else if (ex_op_s == MD_MTHI) begin
          hi_d = rsdataEX;
        end else if (ex_op_s == MD_MTLO) begin
          lo_d = rsdataEX;
        end else begin
          hi_d = hi_q;
        end
      end
      ST_BUSY: begin
        // MDU ops seen in EX here are ignored; the D-stage stall keeps them out in practice
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          if (arith_we_s) begin
            hi_d = arith_hi_s;
            lo_d = arith_lo_s;
          end else begin
            hi_d = hi_q;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter, HI/LO and captured operands; async reset aborts any operation in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      op_q    <= MD_NONE;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  // Status, stall and the EX-stage forwarding triple for mfhi/mflo
  always_comb begin
    busy      = (state_q == ST_BUSY);
    stallD    = (d_op_s != MD_NONE) && (busy || start_s);
    mf_read_s = (state_q == ST_IDLE) && ((ex_op_s == MD_MFHI) || (ex_op_s == MD_MFLO));
    if (state_q == ST_IDLE && ex_op_s == MD_MFHI) begin
      mdOutEX = hi_q;
    end else if (state_q == ST_IDLE && ex_op_s == MD_MFLO) begin
      mdOutEX = lo_q;
    end else begin
      mdOutEX = 32'd0;
    end
    RegWrite = mf_read_s;
    RegData  = mdOutEX;
    RegAddr  = mf_read_s ? instrEX[15:11] : 5'd0;
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: expected HI/LO pairs are queued at issue and checked via mfhi/mflo.
module tb_mdu_ctrl;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [31:0] NOP    = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } hilo_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] instrEX, instrD, rsdataEX, rtdataEX;
  logic        busy, stallD, RegWrite;
  logic [31:0] mdOutEX, RegData;
  logic [4:0]  RegAddr;

  hilo_t       exp_q[$];
  logic [31:0] model_hi = 32'd0;
  logic [31:0] model_lo = 32'd0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  mdu_ctrl dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .instrEX  (instrEX),
    .instrD   (instrD),
    .rsdataEX (rsdataEX),
    .rtdataEX (rtdataEX),
    .busy     (busy),
    .stallD   (stallD),
    .mdOutEX  (mdOutEX),
    .RegWrite (RegWrite),
    .RegData  (RegData),
    .RegAddr  (RegAddr)
  );

  function automatic logic [31:0] rtype(input logic [5:0] func, input logic [4:0] rd);
    return {6'd0, 5'd3, 5'd4, rd, 5'd0, func};
  endfunction

  task automatic push_model();
    hilo_t e;
    e.hi = model_hi;
    e.lo = model_lo;
    exp_q.push_back(e);
  endtask

  task automatic read_hilo(input string tag);
    hilo_t e;
    e = '0;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: scoreboard empty, got nothing required an entry", tag);
    end else begin
      e = exp_q.pop_front();
    end
    @(negedge clk);
    instrEX = rtype(F_MFHI, 5'd7);
    #1;
    checks++;
    if (mdOutEX !== e.hi) begin
      errors++; $display("FAIL %s hi: got %h required %h", tag, mdOutEX, e.hi);
    end
    checks++;
    if (RegWrite !== 1'b1 || RegAddr !== 5'd7 || RegData !== e.hi) begin
      errors++; $display("FAIL %s fwd_hi: got %b/%0d/%h required 1/7/%h", tag, RegWrite, RegAddr, RegData, e.hi);
    end
    instrEX = rtype(F_MFLO, 5'd9);
    #1;
    checks++;
    if (mdOutEX !== e.lo) begin
      errors++; $display("FAIL %s lo: got %h required %h", tag, mdOutEX, e.lo);
    end
    checks++;
    if (RegWrite !== 1'b1 || RegAddr !== 5'd9 || RegData !== e.lo) begin
      errors++; $display("FAIL %s fwd_lo: got %b/%0d/%h required 1/9/%h", tag, RegWrite, RegAddr, RegData, e.lo);
    end
    instrEX = NOP;
    #1;
    checks++;
    if (RegWrite !== 1'b0 || RegData !== 32'd0 || RegAddr !== 5'd0 || mdOutEX !== 32'd0) begin
      errors++; $display("FAIL %s fwd_idle: got %b/%0d/%h/%h required all zero", tag, RegWrite, RegAddr, RegData, mdOutEX);
    end
  endtask

  // Issue one op, scramble operands afterwards, count busy cycles and check stall on each
  task automatic run_op(input logic [5:0] func, input logic [31:0] rs, input logic [31:0] rt,
                        input logic [31:0] d_instr, input logic [31:0] busy_ex,
                        input int exp_n, input logic exp_stall, input string tag);
    int  n;
    logic done;
    @(negedge clk);
    instrEX = rtype(func, 5'd1); rsdataEX = rs; rtdataEX = rt; instrD = d_instr;
    #1;
    checks++;
    if (busy !== 1'b0 || stallD !== exp_stall) begin
      errors++; $display("FAIL %s start: got busy=%b stall=%b required busy=0 stall=%b", tag, busy, stallD, exp_stall);
    end
    @(negedge clk);
    instrEX = busy_ex; rsdataEX = ~rs; rtdataEX = rt ^ 32'h5A5A_5A5A;
    n = 0; done = 1'b0;
    for (int c = 0; c < 64; c++) begin
      #1;
      if (!busy) begin
        done = 1'b1;
        break;
      end
      n++;
      checks++;
      if (stallD !== exp_stall) begin
        errors++; $display("FAIL %s busy_stall: got %b required %b at busy cycle %0d", tag, stallD, exp_stall, n);
      end
      @(negedge clk);
    end
    instrEX = NOP;
    checks++;
    if (!done || n != exp_n) begin
      errors++; $display("FAIL %s busy_len: got %0d required %0d (ended=%b)", tag, n, exp_n, done);
    end
    #1;
    checks++;
    if (stallD !== 1'b0) begin
      errors++; $display("FAIL %s post_stall: got %b required 0", tag, stallD);
    end
    instrD = NOP;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; instrEX = NOP; instrD = NOP; rsdataEX = 32'd0; rtdataEX = 32'd0;
    #2;
    checks++;
    if (busy !== 1'b0 || stallD !== 1'b0 || RegWrite !== 1'b0 || mdOutEX !== 32'd0) begin
      errors++; $display("FAIL reset_outs: got busy=%b stall=%b rw=%b md=%h required 0/0/0/0", busy, stallD, RegWrite, mdOutEX);
    end
    instrEX = rtype(F_MULT, 5'd1); instrD = rtype(F_MFLO, 5'd2);
    #1;
    checks++;
    if (stallD !== 1'b1) begin
      errors++; $display("FAIL reset_comb_stall: got %b required 1", stallD);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_hold_idle: got busy=%b required 0", busy);
    end
    @(negedge clk);
    instrEX = NOP; instrD = NOP; reset_n = 1'b1;
    push_model();
    read_hilo("reset_hilo");
  endtask

  task automatic test_mult();
    run_op(F_MULT, 32'hFFFF_FFFE, 32'd3, NOP, NOP, 5, 1'b0, "mult");
    model_hi = 32'hFFFF_FFFF; model_lo = 32'hFFFF_FFFA;
    push_model();
    read_hilo("mult_res");
    run_op(F_MULTU, 32'hFFFF_FFFF, 32'd2, NOP, NOP, 5, 1'b0, "multu");
    model_hi = 32'h0000_0001; model_lo = 32'hFFFF_FFFE;
    push_model();
    read_hilo("multu_res");
  endtask

  task automatic test_mthi_mtlo();
    @(negedge clk);
    instrEX = rtype(F_MTHI, 5'd0); rsdataEX = 32'h1234_5678;
    model_hi = 32'h1234_5678;
    push_model();
    read_hilo("mthi");
    @(negedge clk);
    instrEX = rtype(F_MTLO, 5'd0); rsdataEX = 32'hCAFE_BABE;
    model_lo = 32'hCAFE_BABE;
    push_model();
    read_hilo("mtlo");
  endtask

  task automatic test_stall();
    run_op(F_MULT, 32'd2, 32'd3, rtype(F_MFLO, 5'd11), NOP, 5, 1'b1, "stall_mflo");
    model_hi = 32'd0; model_lo = 32'd6;
    push_model();
    read_hilo("stall_mflo_res");
    run_op(F_MULTU, 32'd10, 32'd10, rtype(F_MTLO, 5'd0), NOP, 5, 1'b1, "stall_mtlo");
    model_lo = 32'd100;
    run_op(F_MULT, 32'd4, 32'd5, rtype(F_ADDU, 5'd2), NOP, 5, 1'b0, "nostall_addu");
    model_lo = 32'd20;
    push_model();
    read_hilo("stall_res");
  endtask

  task automatic test_div();
`ifdef MDU_DIV_EN
    run_op(F_DIV, 32'hFFFF_FFF9, 32'd2, NOP, NOP, 10, 1'b0, "div");
    model_hi = 32'hFFFF_FFFF; model_lo = 32'hFFFF_FFFD;
    push_model();
    read_hilo("div_res");
    run_op(F_DIV, 32'd7, 32'hFFFF_FFFE, NOP, NOP, 10, 1'b0, "div_negdiv");
    model_hi = 32'd1; model_lo = 32'hFFFF_FFFD;
    push_model();
    read_hilo("div_negdiv_res");
    run_op(F_DIVU, 32'd100, 32'd7, rtype(F_MFHI, 5'd3), NOP, 10, 1'b1, "divu");
    model_hi = 32'd2; model_lo = 32'd14;
    push_model();
    read_hilo("divu_res");
    run_op(F_DIV, 32'd55, 32'd0, NOP, NOP, 10, 1'b0, "div_zero");
    push_model();
    read_hilo("div_zero_res");
`else
    run_op(F_DIV, 32'hFFFF_FFF9, 32'd2, rtype(F_DIV, 5'd0), NOP, 0, 1'b0, "div_noop");
    run_op(F_MULT, 32'd3, 32'd3, rtype(F_DIVU, 5'd0), NOP, 5, 1'b0, "divu_nostall");
    model_hi = 32'd0; model_lo = 32'd9;
    run_op(F_DIVU, 32'd100, 32'd7, NOP, NOP, 0, 1'b0, "divu_noop");
    push_model();
    read_hilo("div_noop_res");
`endif
  endtask

  // Ops placed in EX while busy must be ignored; a new op follows immediately after
  task automatic test_back_to_back();
    run_op(F_MULT, 32'hFFFF_FFFB, 32'hFFFF_FFFA, NOP, rtype(F_MTHI, 5'd0), 5, 1'b0, "b2b_a");
    model_hi = 32'd0; model_lo = 32'd30;
    push_model();
    read_hilo("b2b_a_res");
    run_op(F_MULT, 32'h7FFF_FFFF, 32'h7FFF_FFFF, NOP, rtype(F_MTLO, 5'd0), 5, 1'b0, "b2b_b");
    model_hi = 32'h3FFF_FFFF; model_lo = 32'h0000_0001;
    push_model();
    read_hilo("b2b_b_res");
  endtask

  task automatic test_reset_busy();
    logic stayed_idle;
    @(negedge clk);
`ifdef MDU_DIV_EN
    instrEX = rtype(F_DIV, 5'd1); rsdataEX = 32'hFFFF_FFF9; rtdataEX = 32'd2;
`else
    instrEX = rtype(F_MULT, 5'd1); rsdataEX = 32'd9; rtdataEX = 32'd9;
`endif
    @(negedge clk);
    instrEX = NOP; instrD = rtype(F_MFLO, 5'd4);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || stallD !== 1'b0) begin
      errors++; $display("FAIL rst_busy_abort: got busy=%b stall=%b required 0/0", busy, stallD);
    end
    instrEX = rtype(F_MFHI, 5'd5);
    #1;
    checks++;
    if (mdOutEX !== 32'd0) begin
      errors++; $display("FAIL rst_busy_hi: got %h required 00000000", mdOutEX);
    end
    instrEX = NOP;
    @(negedge clk);
    reset_n = 1'b1; instrD = NOP;
    stayed_idle = 1'b1;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk); #1;
      if (busy !== 1'b0) stayed_idle = 1'b0;
    end
    checks++;
    if (!stayed_idle) begin
      errors++; $display("FAIL rst_busy_idle: got busy during recovery required 0");
    end
    model_hi = 32'd0; model_lo = 32'd0;
    push_model();
    read_hilo("rst_busy_res");
  endtask

  initial begin
    test_reset();
    test_mult();
    test_mthi_mtlo();
    test_stall();
    test_div();
    test_back_to_back();
    test_reset_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
